hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the decode/issue/EXE/MEM/WB signals seen by the hazard scoreboard.
//   master : pipeline side, drives indices, use/write flags, issue and branch
//            info; receives forward selects and stall/flush controls.
//   slave  : scoreboard side (mirror of master).
// Parameters: REG_CNT (architectural registers), LAT_W (latency width).
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int REG_CNT = 32,
  parameter int LAT_W   = 3
);
  localparam int IDX_W = $clog2(REG_CNT);

  logic [IDX_W-1:0] rs1_dec, rs2_dec;
  logic             rs1_use_dec, rs2_use_dec;
  logic             issue_valid, issue_wr;
  logic [IDX_W-1:0] issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic [IDX_W-1:0] rs1_exe, rs2_exe, rd_mem, rd_wb;
  logic             reg_write_mem, reg_write_wb;
  logic             took_branch;
  logic [1:0]       fwd_rs1_exe, fwd_rs2_exe;
  logic             stall_fetch, stall_dec, flush_exe;

  modport master (
    output rs1_dec, rs2_dec, rs1_use_dec, rs2_use_dec,
           issue_valid, issue_wr, issue_rd, issue_lat,
           rs1_exe, rs2_exe, rd_mem, rd_wb,
           reg_write_mem, reg_write_wb, took_branch,
    input  fwd_rs1_exe, fwd_rs2_exe, stall_fetch, stall_dec, flush_exe
  );

  modport slave (
    input  rs1_dec, rs2_dec, rs1_use_dec, rs2_use_dec,
           issue_valid, issue_wr, issue_rd, issue_lat,
           rs1_exe, rs2_exe, rd_mem, rd_wb,
           reg_write_mem, reg_write_wb, took_branch,
    output fwd_rs1_exe, fwd_rs2_exe, stall_fetch, stall_dec, flush_exe
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register latency scoreboard producing RAW/WAW stalls, EXE flush and
// EXE operand forward selects for an in-order pipeline.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   hz    : hazard_scoreboard_if.slave (decode/issue/EXE/MEM/WB bundle)
// Forward select encoding: NO_FW=2'd0, FW_MEM=2'd1, FW_WB=2'd2.
// Optional feature macro: HAZARD_FWD_EN
//   defined   : results forwardable from MEM/WB; a source stalls while its
//               counter is >= 2.
//   undefined : no forwarding; a source stalls while its counter is >= 1 or
//               the WB stage is writing it; forward selects are NO_FW.
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_CNT = 32,
  parameter int LAT_W   = 3,
  parameter int MAX_LAT = 7
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave hz
);
  localparam int IDX_W = $clog2(REG_CNT);
  localparam logic [1:0] NO_FW  = 2'd0;
  localparam logic [1:0] FW_MEM = 2'd1;
  localparam logic [1:0] FW_WB  = 2'd2;

  if (MAX_LAT > (1 << LAT_W) - 1) begin : g_bad_max_lat
    $error("MAX_LAT does not fit in LAT_W bits");
  end

  logic [LAT_W-1:0] cnt_q [REG_CNT];
  logic [LAT_W-1:0] cnt_d [REG_CNT];
  logic             last_vld_q, last_vld_d;
  logic [IDX_W-1:0] last_rd_q, last_rd_d;
  logic [LAT_W-1:0] last_prev_q, last_prev_d;

  logic raw1, raw2, raw_hazard, waw_hazard, stall, load;

  // Counter value two cycles after it was sampled, floored at zero.
  function automatic logic [LAT_W-1:0] sat_sub2(input logic [LAT_W-1:0] v);
    return (v > LAT_W'(2)) ? v - LAT_W'(2) : '0;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [IDX_W-1:0] src,
                                         input logic             wr_mem,
                                         input logic [IDX_W-1:0] rd_m,
                                         input logic             wr_wb,
                                         input logic [IDX_W-1:0] rd_w);
    if (src == '0)                  return NO_FW;
    else if (wr_mem && rd_m == src) return FW_MEM;
    else if (wr_wb && rd_w == src)  return FW_WB;
    else                            return NO_FW;
  endfunction

`ifdef HAZARD_FWD_EN
  // With forwarding, a value with one cycle left is picked up from MEM/WB.
  assign raw1 = hz.rs1_use_dec && (hz.rs1_dec != '0) && (cnt_q[hz.rs1_dec] >= LAT_W'(2));
  assign raw2 = hz.rs2_use_dec && (hz.rs2_dec != '0) && (cnt_q[hz.rs2_dec] >= LAT_W'(2));
  assign hz.fwd_rs1_exe = fwd_sel(hz.rs1_exe, hz.reg_write_mem, hz.rd_mem,
                                  hz.reg_write_wb, hz.rd_wb);
  assign hz.fwd_rs2_exe = fwd_sel(hz.rs2_exe, hz.reg_write_mem, hz.rd_mem,
                                  hz.reg_write_wb, hz.rd_wb);
`else
  // Without forwarding, wait until the register file write in WB completes.
  assign raw1 = hz.rs1_use_dec && (hz.rs1_dec != '0) &&
                ((cnt_q[hz.rs1_dec] >= LAT_W'(1)) || (hz.reg_write_wb && hz.rd_wb == hz.rs1_dec));
  assign raw2 = hz.rs2_use_dec && (hz.rs2_dec != '0) &&
                ((cnt_q[hz.rs2_dec] >= LAT_W'(1)) || (hz.reg_write_wb && hz.rd_wb == hz.rs2_dec));
  assign hz.fwd_rs1_exe = NO_FW;
  assign hz.fwd_rs2_exe = NO_FW;
  logic unused_fwd;
  assign unused_fwd = ^{hz.rs1_exe, hz.rs2_exe, hz.rd_mem, hz.reg_write_mem,
                        fwd_sel(hz.rs1_exe, hz.reg_write_mem, hz.rd_mem,
                                hz.reg_write_wb, hz.rd_wb)};
`endif

  assign raw_hazard = raw1 || raw2;
  // A younger write must not complete before an older pending one.
  assign waw_hazard = hz.issue_valid && hz.issue_wr && (hz.issue_rd != '0) &&
                      (cnt_q[hz.issue_rd] > hz.issue_lat);
  assign stall          = hz.issue_valid && (raw_hazard || waw_hazard);
  assign hz.stall_fetch = stall;
  assign hz.stall_dec   = stall;
  assign hz.flush_exe   = stall || hz.took_branch;

  assign load = hz.issue_valid && !stall && !hz.took_branch &&
                hz.issue_wr && (hz.issue_rd != '0);

  always_comb begin
    for (int r = 0; r < REG_CNT; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
    end
    last_vld_d  = 1'b0;
    last_rd_d   = last_rd_q;
    last_prev_d = last_prev_q;
    if (load) begin
      cnt_d[hz.issue_rd] = hz.issue_lat;
      last_vld_d         = 1'b1;
      last_rd_d          = hz.issue_rd;
      last_prev_d        = cnt_q[hz.issue_rd];
    end
    // The flushed EXE instruction was the last issue; put back what the older
    // pending write would have counted down to by now.
    if (hz.took_branch && last_vld_q) begin
      cnt_d[last_rd_q] = sat_sub2(last_prev_q);
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_CNT; r++) cnt_q[r] <= '0;
      last_vld_q  <= 1'b0;
      last_rd_q   <= '0;
      last_prev_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_vld_q  <= last_vld_d;
      last_rd_q   <= last_rd_d;
      last_prev_q <= last_prev_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Drives hazard_scoreboard with directed scenarios and random traffic and
// compares every control output with a reference model that tracks, per
// register, the absolute cycle at which its pending result becomes available.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
  localparam int REG_CNT = 32;
  localparam int LAT_W   = 3;
  localparam int MAX_LAT = 7;
  localparam logic [1:0] NO_FW  = 2'd0;
  localparam logic [1:0] FW_MEM = 2'd1;
  localparam logic [1:0] FW_WB  = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_CNT(REG_CNT), .LAT_W(LAT_W)) hz ();

  hazard_scoreboard #(.REG_CNT(REG_CNT), .LAT_W(LAT_W), .MAX_LAT(MAX_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: done[r] = cycle at which register r has no pending write.
  longint done [REG_CNT];
  longint t;
  bit     lv;
  int     lrd;
  longint lprev_done;

  function automatic longint rem(input int r);
    return (done[r] > t) ? done[r] - t : 0;
  endfunction

  task automatic model_reset();
    foreach (done[r]) done[r] = 0;
    t = 0; lv = 0; lrd = 0; lprev_done = 0;
  endtask

  function automatic bit src_raw(input bit use_f, input int src);
    if (!use_f || src == 0) return 0;
`ifdef HAZARD_FWD_EN
    return rem(src) >= 2;
`else
    return (rem(src) >= 1) || (hz.reg_write_wb && int'(hz.rd_wb) == src);
`endif
  endfunction

  function automatic logic [1:0] exp_fwd(input int src);
`ifdef HAZARD_FWD_EN
    if (src == 0) return NO_FW;
    if (hz.reg_write_mem && int'(hz.rd_mem) == src) return FW_MEM;
    if (hz.reg_write_wb && int'(hz.rd_wb) == src) return FW_WB;
`endif
    return NO_FW;
  endfunction

  // Inputs are already set (just after negedge); check, advance model, move on.
  task automatic cycle();
    bit raw, waw, stall, acc;
    int rd;
    #1;
    rd    = int'(hz.issue_rd);
    raw   = src_raw(hz.rs1_use_dec, int'(hz.rs1_dec)) || src_raw(hz.rs2_use_dec, int'(hz.rs2_dec));
    waw   = hz.issue_valid && hz.issue_wr && rd != 0 && rem(rd) > longint'(hz.issue_lat);
    stall = hz.issue_valid && (raw || waw);
    chk("stall_fetch", hz.stall_fetch, stall);
    chk("stall_dec",   hz.stall_dec,   stall);
    chk("flush_exe",   hz.flush_exe,   stall || hz.took_branch);
    chk("fwd_rs1",     hz.fwd_rs1_exe, exp_fwd(int'(hz.rs1_exe)));
    chk("fwd_rs2",     hz.fwd_rs2_exe, exp_fwd(int'(hz.rs2_exe)));
    acc = hz.issue_valid && !stall && !hz.took_branch;
    if (hz.took_branch && lv) done[lrd] = lprev_done;
    if (acc && hz.issue_wr && rd != 0) begin
      lv = 1; lrd = rd; lprev_done = done[rd];
      done[rd] = t + 1 + longint'(hz.issue_lat);
    end else begin
      lv = 0;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle();
    hz.rs1_dec = '0; hz.rs2_dec = '0; hz.rs1_use_dec = 0; hz.rs2_use_dec = 0;
    hz.issue_valid = 0; hz.issue_wr = 0; hz.issue_rd = '0; hz.issue_lat = 3'd1;
    hz.rs1_exe = '0; hz.rs2_exe = '0; hz.rd_mem = '0; hz.rd_wb = '0;
    hz.reg_write_mem = 0; hz.reg_write_wb = 0; hz.took_branch = 0;
  endtask

  task automatic issue(input int rd, input int lat);
    hz.issue_valid = 1; hz.issue_wr = 1;
    hz.issue_rd = 5'(rd); hz.issue_lat = 3'(lat);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_stall", hz.stall_dec, 1'b0);
    #1;
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_fetch", hz.stall_fetch, 1'b0);
    chk("reset_flush",       hz.flush_exe,   1'b0);
    @(negedge clk);
    rst_n = 1;

    // Dependent read right behind a 3-cycle producer.
    idle(); issue(5, 3); cycle();
    idle(); hz.issue_valid = 1; hz.rs1_dec = 5'd5; hz.rs1_use_dec = 1;
    repeat (4) cycle();

    // x0 never becomes busy.
    idle(); issue(0, 7); hz.rs1_dec = '0; hz.rs1_use_dec = 1; cycle();
    idle(); hz.issue_valid = 1; hz.rs1_use_dec = 1; cycle();

    // WAW: long write to x7 followed by a short one.
    idle(); issue(7, 5); cycle();
    idle(); issue(7, 2); repeat (4) cycle();
    idle(); repeat (3) cycle();

    // Branch squashes the issue just made.
    idle(); issue(9, 4); cycle();
    idle(); hz.took_branch = 1; cycle();
    idle(); hz.issue_valid = 1; hz.rs1_dec = 5'd9; hz.rs1_use_dec = 1; repeat (3) cycle();

    // Branch squash keeping an older pending write.
    idle(); issue(11, 6); cycle();
    idle(); issue(11, 6); cycle();
    idle(); hz.took_branch = 1; cycle();
    idle(); hz.issue_valid = 1; hz.rs2_dec = 5'd11; hz.rs2_use_dec = 1; repeat (6) cycle();

    // Forward selection priority.
    idle(); hz.rs1_exe = 5'd3; hz.rd_mem = 5'd3; hz.rd_wb = 5'd3;
    hz.reg_write_mem = 1; hz.reg_write_wb = 1; cycle();
    hz.rs1_exe = 5'd3; hz.rd_mem = 5'd3; hz.rd_wb = 5'd3;
    hz.reg_write_mem = 0; hz.reg_write_wb = 1; cycle();
    hz.rs1_exe = '0; hz.reg_write_mem = 1; cycle();

    // Reset drops pending entries.
    idle(); issue(4, 6); cycle();
    idle(); pulse_reset();
    hz.issue_valid = 1; hz.rs2_dec = 5'd4; hz.rs2_use_dec = 1; cycle();

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      hz.rs1_dec       = 5'($urandom_range(0, 7));
      hz.rs2_dec       = 5'($urandom_range(0, 7));
      hz.rs1_use_dec   = 1'($urandom_range(0, 1));
      hz.rs2_use_dec   = 1'($urandom_range(0, 1));
      hz.issue_valid   = ($urandom_range(0, 3) != 0);
      hz.issue_wr      = ($urandom_range(0, 3) != 0);
      hz.issue_rd      = 5'($urandom_range(0, 7));
      hz.issue_lat     = 3'($urandom_range(1, MAX_LAT));
      hz.rs1_exe       = 5'($urandom_range(0, 7));
      hz.rs2_exe       = 5'($urandom_range(0, 7));
      hz.rd_mem        = 5'($urandom_range(0, 7));
      hz.rd_wb         = 5'($urandom_range(0, 7));
      hz.reg_write_mem = 1'($urandom_range(0, 1));
      hz.reg_write_wb  = 1'($urandom_range(0, 1));
      hz.took_branch   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end
endmodule
